// File: rtl/pong_pkg.sv
// Shared types, geometry constants and small helpers for the Pong game engine.
// All coordinates are in VGA hCount/vCount space.
package pong_pkg;

    typedef logic [9:0]        coord_t;
    typedef logic signed [10:0] scoord_t;
    typedef logic [3:0]        score_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam coord_t FIELD_LEFT   = 10'd144;
    localparam coord_t FIELD_RIGHT  = 10'd783;
    localparam coord_t FIELD_TOP    = 10'd35;
    localparam coord_t FIELD_BOTTOM = 10'd514;
    localparam coord_t P1_X         = 10'd150;
    localparam coord_t P2_X         = 10'd760;
    localparam coord_t PADDLE_W     = 10'd20;
    localparam coord_t PADDLE_H     = 10'd40;
    localparam coord_t BALL_SIZE    = 10'd8;
    localparam coord_t PADDLE_STEP  = 10'd2;
    localparam coord_t BALL_STEP    = 10'd2;

    localparam logic [5:0] SERVE_FRAMES = 6'd60;
    localparam logic [5:0] SERVE_LAST   = SERVE_FRAMES - 6'd1;
    localparam score_t     WIN_SCORE    = 4'd9;

    // Centre positions and clamp limits derived from the field geometry.
    localparam coord_t PC         = (FIELD_TOP + FIELD_BOTTOM + 10'd1) / 10'd2 - PADDLE_H / 10'd2;
    localparam coord_t BX         = (FIELD_LEFT + FIELD_RIGHT + 10'd1) / 10'd2 - BALL_SIZE / 10'd2;
    localparam coord_t BY         = (FIELD_TOP + FIELD_BOTTOM + 10'd1) / 10'd2 - BALL_SIZE / 10'd2;
    localparam coord_t PADDLE_MIN = FIELD_TOP;
    localparam coord_t PADDLE_MAX = FIELD_BOTTOM - PADDLE_H + 10'd1;
    localparam coord_t BALL_Y_MAX = FIELD_BOTTOM - BALL_SIZE + 10'd1;
    localparam coord_t BALL_X_MAX = FIELD_RIGHT - BALL_SIZE + 10'd1;
    localparam coord_t HIT1_X     = P1_X + PADDLE_W;
    localparam coord_t HIT2_X     = P2_X - BALL_SIZE;

    function automatic scoord_t to_signed(input coord_t c);
        return $signed({1'b0, c});
    endfunction

    // True when the ball rows overlap the paddle rows.
    function automatic logic overlaps(input coord_t by, input coord_t py);
        return (by + BALL_SIZE - 10'd1 >= py) && (by <= py + PADDLE_H - 10'd1);
    endfunction

    function automatic score_t sat_inc(input score_t s);
        return (s >= WIN_SCORE) ? WIN_SCORE : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_game_engine_if.sv
// Control inputs and game-state outputs exchanged between the engine and its
// surroundings (VGA timing, buttons, renderer, seven-segment driver).
interface pong_game_engine_if;

    logic        frame_tick;
    logic        start;
    logic        up1;
    logic        down1;
    logic        up2;
    logic        down2;
    logic [9:0]  paddle1_y;
    logic [9:0]  paddle2_y;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [15:0] score;
    logic [2:0]  game_state;
    logic        point_pulse;

    modport master (
        output frame_tick, start, up1, down1, up2, down2,
        input  paddle1_y, paddle2_y, ball_x, ball_y, score, game_state, point_pulse
    );

    modport slave (
        input  frame_tick, start, up1, down1, up2, down2,
        output paddle1_y, paddle2_y, ball_x, ball_y, score, game_state, point_pulse
    );

endinterface

// File: rtl/pong_paddle_ctrl.sv
// One paddle's vertical position: steps per frame on up/down and clamps to
// the playfield; recentre snaps it back to the centre row.
module pong_paddle_ctrl
    import pong_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   frame_tick,
    input  logic   enable,
    input  logic   recentre,
    input  logic   up,
    input  logic   down,
    output coord_t y
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= PC;
        end else if (recentre) begin
            y <= PC;
        end else if (frame_tick && enable && (up ^ down)) begin
            if (up) begin
                y <= (y <= PADDLE_MIN + PADDLE_STEP) ? PADDLE_MIN : y - PADDLE_STEP;
            end else begin
                y <= (y >= PADDLE_MAX - PADDLE_STEP) ? PADDLE_MAX : y + PADDLE_STEP;
            end
        end
    end

endmodule

// File: rtl/pong_game_engine.sv
// Per-frame Pong state engine: serve/play/point/over sequencing, ball motion
// with wall and paddle bounces, scoring, and the two paddle controllers.
module pong_game_engine
    import pong_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    pong_game_engine_if.slave bus
);

    state_t     state;
    coord_t     ball_x;
    coord_t     ball_y;
    logic       vx_right;
    logic       vy_down;
    logic       serve_right;
    logic       scorer_p1;
    logic [5:0] frame_cnt;
    score_t     score1;
    score_t     score2;
    logic       point_pulse;

    coord_t     paddle1_y;
    coord_t     paddle2_y;
    logic       paddle_en;
    logic       paddle_recentre;

    assign paddle_en       = (state == SERVE) || (state == PLAY);
    assign paddle_recentre = (state == OVER) && bus.start;

    pong_paddle_ctrl u_paddle1 (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (bus.frame_tick),
        .enable     (paddle_en),
        .recentre   (paddle_recentre),
        .up         (bus.up1),
        .down       (bus.down1),
        .y          (paddle1_y)
    );

    pong_paddle_ctrl u_paddle2 (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (bus.frame_tick),
        .enable     (paddle_en),
        .recentre   (paddle_recentre),
        .up         (bus.up2),
        .down       (bus.down2),
        .y          (paddle2_y)
    );

    scoord_t next_x;
    scoord_t next_y;
    coord_t  ball_x_n;
    coord_t  ball_y_n;
    logic    vx_n;
    logic    vy_n;
    logic    miss;
    logic    miss_p1;
    score_t  new_score;

    // Signed 11-bit arithmetic keeps a step below column/row 0 from wrapping.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_x   = vx_right ? to_signed(ball_x) + to_signed(BALL_STEP)
                            : to_signed(ball_x) - to_signed(BALL_STEP);
        next_y   = vy_down  ? to_signed(ball_y) + to_signed(BALL_STEP)
                            : to_signed(ball_y) - to_signed(BALL_STEP);
        ball_x_n = next_x[9:0];
        ball_y_n = next_y[9:0];
        vx_n     = vx_right;
        vy_n     = vy_down;
        miss     = 1'b0;
        miss_p1  = 1'b0;

        // Paddle hits are tested before misses so a hit always wins.
        if (!vx_right && (ball_x >= HIT1_X) && (next_x < to_signed(HIT1_X))
                && overlaps(ball_y, paddle1_y)) begin
            ball_x_n = HIT1_X;
            vx_n     = 1'b1;
        end else if (vx_right && (ball_x <= HIT2_X) && (next_x > to_signed(HIT2_X))
                && overlaps(ball_y, paddle2_y)) begin
            ball_x_n = HIT2_X;
            vx_n     = 1'b0;
        end else if (next_x <= to_signed(FIELD_LEFT)) begin
            ball_x_n = FIELD_LEFT;
            miss     = 1'b1;
        end else if (next_x >= to_signed(BALL_X_MAX)) begin
            ball_x_n = BALL_X_MAX;
            miss     = 1'b1;
            miss_p1  = 1'b1;
        end

        if (next_y <= to_signed(FIELD_TOP)) begin
            ball_y_n = FIELD_TOP;
            vy_n     = 1'b1;
        end else if (next_y >= to_signed(BALL_Y_MAX)) begin
            ball_y_n = BALL_Y_MAX;
            vy_n     = 1'b0;
        end
    end

    assign new_score = sat_inc(scorer_p1 ? score1 : score2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ball_x      <= BX;
            ball_y      <= BY;
            vx_right    <= 1'b1;
            vy_down     <= 1'b1;
            serve_right <= 1'b1;
            scorer_p1   <= 1'b0;
            frame_cnt   <= '0;
            score1      <= '0;
            score2      <= '0;
            point_pulse <= 1'b0;
        end else begin
            point_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= SERVE;
                        frame_cnt <= '0;
                        vx_right  <= serve_right;
                    end
                end
                SERVE: begin
                    if (bus.frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            // Launch tick: the ball takes its first step now.
                            state     <= PLAY;
                            frame_cnt <= '0;
                            ball_x    <= ball_x_n;
                            ball_y    <= ball_y_n;
                            vx_right  <= vx_n;
                            vy_down   <= vy_n;
                        end else begin
                            frame_cnt <= frame_cnt + 6'd1;
                        end
                    end
                end
                PLAY: begin
                    if (bus.frame_tick) begin
                        ball_x   <= ball_x_n;
                        ball_y   <= ball_y_n;
                        vx_right <= vx_n;
                        vy_down  <= vy_n;
                        if (miss) begin
                            state       <= POINT;
                            scorer_p1   <= miss_p1;
                            serve_right <= miss_p1;
                        end
                    end
                end
                POINT: begin
                    if (bus.frame_tick) begin
                        point_pulse <= 1'b1;
                        if (scorer_p1) score1 <= new_score;
                        else           score2 <= new_score;
                        if (new_score == WIN_SCORE) begin
                            state <= OVER;
                        end else begin
                            state     <= SERVE;
                            ball_x    <= BX;
                            ball_y    <= BY;
                            frame_cnt <= '0;
                            vx_right  <= serve_right;
                        end
                    end
                end
                OVER: begin
                    if (bus.start) begin
                        state  <= IDLE;
                        score1 <= '0;
                        score2 <= '0;
                        ball_x <= BX;
                        ball_y <= BY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.paddle1_y   = paddle1_y;
    assign bus.paddle2_y   = paddle2_y;
    assign bus.ball_x      = ball_x;
    assign bus.ball_y      = ball_y;
    assign bus.score       = {4'h0, score1, 4'h0, score2};
    assign bus.game_state  = state;
    assign bus.point_pulse = point_pulse;

endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
- Per-frame game-state engine for two-player Pong.
- Sits directly upstream of the pixel renderer and feeds it paddle positions, ball position and packed score.
- Advances one step per frame_tick, a one-cycle pulse from the VGA timing block at the start of vertical blanking.
- Owns the serve/play/point/game-over sequencing, paddle clamping, wall and paddle bounces, and scoring.

Parameters:
- FIELD_LEFT, 144, first visible hCount column.
- FIELD_RIGHT, 783, last visible hCount column.
- FIELD_TOP, 35, first visible vCount row.
- FIELD_BOTTOM, 514, last visible vCount row.
- P1_X, 150, left paddle left edge.
- P2_X, 760, right paddle left edge.
- PADDLE_W, 20, paddle width in pixels.
- PADDLE_H, 40, paddle height in pixels.
- BALL_SIZE, 8, ball square side in pixels.
- PADDLE_STEP, 2, paddle pixels per frame.
- BALL_STEP, 2, ball pixels per frame per axis.
- SERVE_FRAMES, 60, frames held in SERVE before launch.
- WIN_SCORE, 9, points needed to win.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, synchronous to clk.
- start  in  1  debounced single-cycle start pulse.
- up1, down1, up2, down2  in  1 each  debounced level inputs for paddle motion.
- paddle1_y  out  10  left paddle top row.
- paddle2_y  out  10  right paddle top row.
- ball_x  out  10  ball left column.
- ball_y  out  10  ball top row.
- score  out  16  {4'h0, score1, 4'h0, score2}; one hex digit per player, for the seven-segment driver.
- game_state  out  3  current FSM state encoding.
- point_pulse  out  1  one-cycle pulse when a point is awarded.

Behaviour:
- Reset values:
  - paddles at PC = (FIELD_TOP+FIELD_BOTTOM+1)/2 - PADDLE_H/2 = 255.
  - ball_x = BX = 460; ball_y = BY = 271 (field centre minus BALL_SIZE/2).
  - score = 0; point_pulse = 0; state = IDLE.
  - serve direction = right; vy = down.
- Timing:
  - All state changes happen only in a clk cycle where frame_tick = 1, except start handling in IDLE and OVER.
  - Outputs are registered; updated values appear the cycle after the tick.
- FSM states:
  - IDLE (0): ball and paddles centred, paddles frozen. start -> SERVE, with frame counter cleared.
  - SERVE (1): ball held at centre; paddles move. Count frames; after SERVE_FRAMES ticks -> PLAY.
  - PLAY (2): paddles and ball move every tick.
  - POINT (3): entered on a miss. On the next tick, increment the scorer; then go to OVER if the new score equals WIN_SCORE, else SERVE.
  - OVER (4): everything frozen. start -> IDLE, clearing both scores.
  - start in SERVE, PLAY or POINT is ignored.
- Paddle motion:
  - up subtracts PADDLE_STEP and clamps at FIELD_TOP.
  - down adds PADDLE_STEP and clamps at FIELD_BOTTOM-PADDLE_H+1 = 475.
  - up and down together: no motion.
- Ball motion:
  - Next position = current ± BALL_STEP per axis.
  - Compute in 11-bit signed to avoid wrap-around below 0.
- Top/bottom walls:
  - If next_y <= FIELD_TOP: ball_y = FIELD_TOP, vy = down.
  - If next_y >= FIELD_BOTTOM-BALL_SIZE+1: clamp to that row, vy = up.
- Paddle hit, left paddle:
  - Condition: vx left, ball_x >= P1_X+PADDLE_W, and next_x < P1_X+PADDLE_W.
  - Vertical overlap with paddle1 uses the current paddle position.
  - Result: ball_x = P1_X+PADDLE_W, vx = right.
- Paddle hit, right paddle: mirrored against P2_X-BALL_SIZE.
- Miss:
  - next_x <= FIELD_LEFT: point to player 2, next serve goes left (toward the loser).
  - next_x >= FIELD_RIGHT-BALL_SIZE+1: point to player 1, next serve goes right.
  - On a miss the ball freezes at the clamped edge and the state goes to POINT; point_pulse fires on the tick that performs the increment.
- Simultaneous wall and paddle events resolve independently per axis.
- A paddle hit takes priority over a miss in the same tick.
- Scores saturate at WIN_SCORE.
- rst mid-operation returns to the reset values immediately (asynchronous).

Decomposition:
- pong_pkg holds:
  - the state enum (IDLE, SERVE, PLAY, POINT, OVER);
  - the field and paddle geometry constants;
  - the derived constants PC, BX, BY and the paddle clamp limits.
- One sub-module, pong_paddle_ctrl: clamped paddle position register driven by up, down, frame_tick and enable. Instantiated twice.

Test Plan:
- Reset, then start, then 60 ticks -> state goes IDLE->SERVE->PLAY; ball at (460,271) until the 60th tick, then (458 or 462, 273) depending on serve direction.
- up1 held for 120 ticks in SERVE -> paddle1_y steps 255->35 in 110 ticks and holds at 35; down1 held -> clamps at 475; up1+down1 -> no change.
- Free play, bench holds paddles away from the ball -> bounces at vCount 35/507; miss on the right -> point_pulse once, score = 0x0100, state SERVE.
- Bench steers paddle2 to track ball_y -> ball_x reverses at 752; no point awarded; score unchanged.
- Nine consecutive player-1 points -> score = 0x0900, state OVER; start -> IDLE with score = 0x0000.
- rst asserted mid-PLAY between ticks -> all outputs return to reset values the same cycle; start ignored during PLAY.
